spi_master: RTL and testbench

- SPI initiator for the address/data slave's link: generates sclk, cs_n and mosi, and samples miso.
- Each transaction is 7 address bits, then 1 R/W bit, then 8 data bits, all MSB first. This is the framing the slave FSM decodes.
- The system side issues single-byte reads and writes over a valid/ready request port and receives read data with a done pulse.
- Sits between the host/test logic and the off-block SPI pins.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_clkgen.sv | 38 +++
 rtl/spi_master.sv | 125 ++++++++++++
 tb/tb_spi_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: FSM encoding, frame geometry, rw encoding.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_ADDR_W + 1 + DEF_DATA_W;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Frame length for a given address/data split: address, one rw bit, data.
  function automatic int frame_width(input int addr_w, input int data_w);
    return addr_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SPI clock divider: owns the divide counter and produces sclk plus edge ticks.
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic shift_en,
  output logic wrap_tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // The counter also times SETUP/HOLD, but sclk only toggles while shifting.
  assign wrap_tick = cnt_en && (div_cnt == DIV_LAST);
  assign rise_tick = shift_en && wrap_tick && !sclk;
  assign fall_tick = shift_en && wrap_tick && sclk;

  // Divide counter (wraps at CLK_DIV-1) and sclk level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else begin
      if (!cnt_en || wrap_tick) div_cnt <= '0;
      else                      div_cnt <= div_cnt + 1'b1;
      if (rise_tick)                   sclk <= 1'b1;
      else if (fall_tick || !shift_en) sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one {addr, rw, data} frame per accepted request.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int FW    = frame_width(ADDR_W, DATA_W);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [4:0] LAST_BIT = 5'(FW - 1);
  localparam logic [4:0] FIRST_RX = 5'(ADDR_W + 1);

  state_t            state, state_nxt;
  logic              cnt_en, shift_en;
  logic              wrap_tick, rise_tick, fall_tick;
  logic              accept, hold_done;
  logic [FW-1:0]     tx;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] wdata_fill;
  logic              rw_flag;
  logic [4:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_en    (cnt_en),
    .shift_en  (shift_en),
    .wrap_tick (wrap_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  // req_ready is gated by rst_n so it reads low for the whole reset assertion.
  assign req_ready  = rst_n && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign busy       = (state != IDLE);
  assign hold_done  = (state == HOLD) && wrap_tick;
  assign cs_n       = !cnt_en;
  assign mosi       = cnt_en && tx[FW-1];
  assign wdata_fill = (req_rw == RW_READ) ? {DATA_W{1'b0}} : req_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and divider enables.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: begin
        cnt_en = 1'b1;
        if (wrap_tick) state_nxt = SHIFT;
      end
      SHIFT: begin
        cnt_en   = 1'b1;
        shift_en = 1'b1;
        if (fall_tick && (bit_cnt == LAST_BIT)) state_nxt = HOLD;
      end
      HOLD: begin
        cnt_en = 1'b1;
        if (wrap_tick) state_nxt = GAP;
      end
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame shift registers, bit/gap counters and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= '0;
      rx        <= '0;
      rw_flag   <= RW_WRITE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rsp_done  <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_done <= hold_done;
      if (accept) begin
        tx      <= {req_addr, req_rw, wdata_fill};
        rw_flag <= req_rw;
        rx      <= '0;
        bit_cnt <= '0;
      end
      if ((state == SETUP) && wrap_tick) bit_cnt <= '0;
      // mosi only moves on the falling sclk edge, keeping it stable while sclk is high.
      if (fall_tick) begin
        tx      <= {tx[FW-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rise_tick && (rw_flag == RW_READ) && (bit_cnt >= FIRST_RX))
        rx <= {rx[DATA_W-2:0], miso};
      if (hold_done && (rw_flag == RW_READ)) rsp_rdata <= rx;
      if (hold_done)                             gap_cnt <= GAP_W'(CS_GAP - 1);
      else if ((state == GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=4 instance with a slave model, CLK_DIV=2 sweep instance.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: CLK_DIV=4
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_done, busy, sclk, cs_n, mosi;
  logic [7:0] rsp_rdata;
  bit         miso = 1'b0;

  spi_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8), .CS_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  // Instance B: CLK_DIV=2
  logic       b_req_valid = 1'b0, b_req_rw = 1'b0;
  logic [6:0] b_req_addr = '0;
  logic [7:0] b_req_wdata = '0;
  logic       b_req_ready, b_rsp_done, b_busy, b_sclk, b_cs_n, b_mosi;
  logic [7:0] b_rsp_rdata;
  logic       b_miso = 1'b0;

  spi_master #(.CLK_DIV(2), .ADDR_W(7), .DATA_W(8), .CS_GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_rw(b_req_rw), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_done(b_rsp_done), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .sclk(b_sclk), .cs_n(b_cs_n), .mosi(b_mosi), .miso(b_miso)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: 7-bit addr, rw, 8-bit data; unwritten 0x7F reads as 0xA5.
  bit [7:0]   mem [128];
  bit [127:0] written;
  int         s_cnt = 0;
  bit [15:0]  s_sh;
  bit [6:0]   s_addr;
  bit         s_rw;

  function automatic bit [7:0] mem_rd(input bit [6:0] a);
    if (written[a]) return mem[a];
    return (a == 7'h7F) ? 8'hA5 : 8'h00;
  endfunction

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) s_cnt <= 0;
    else begin
      s_sh  <= {s_sh[14:0], mosi};
      s_cnt <= s_cnt + 1;
      if (s_cnt == 15 && !s_sh[7]) begin
        mem[s_sh[14:8]]     <= {s_sh[6:0], mosi};
        written[s_sh[14:8]] <= 1'b1;
      end
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && s_cnt == 8) begin
      s_addr <= s_sh[7:1];
      s_rw   <= s_sh[0];
      miso   <= s_sh[0] ? mem_rd(s_sh[7:1]) >> 7 : 1'b0;
    end else if (!cs_n && s_cnt > 8 && s_cnt < 16) begin
      miso <= s_rw ? mem_rd(s_addr) >> (15 - s_cnt) : 1'b0;
    end
  end

  // Monitor A (sampled on falling clk)
  bit        prev_cs = 1'b1, prev_sclk = 1'b0;
  int        cs_low_cnt = 0, last_cs_low = 0, high_run = 0, last_high_run = 0;
  int        rise_cnt = 0, last_rises = 0;
  bit [15:0] bits, last_bits;
  int        done_cnt = 0, done_edge = 0, prev_done_edge = 0;
  bit [7:0]  done_rdata, prev_done_rdata;
  int        accept_edge = 0, ready_in_frame = 0;

  always @(negedge clk) begin
    if (req_valid && req_ready) accept_edge = cyc + 1;
    if (!cs_n && req_ready) ready_in_frame++;
    if (!cs_n) begin
      if (prev_cs) begin
        last_high_run = high_run;
        high_run = 0;
        rise_cnt = 0;
        bits = '0;
      end
      cs_low_cnt++;
    end else begin
      if (!prev_cs) begin
        last_cs_low = cs_low_cnt;
        cs_low_cnt = 0;
        last_bits = bits;
        last_rises = rise_cnt;
      end
      high_run++;
    end
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      bits = {bits[14:0], mosi};
    end
    if (rsp_done) begin
      done_cnt++;
      prev_done_edge = done_edge;
      done_edge = cyc;
      prev_done_rdata = done_rdata;
      done_rdata = rsp_rdata;
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  // Monitor B (sampled on falling clk)
  bit        b_prev_cs = 1'b1, b_prev_sclk = 1'b0, b_prev_mosi = 1'b0;
  int        b_cs_low = 0, b_last_cs_low = 0, b_rises = 0, b_last_rises = 0;
  int        b_last_rise_cyc = 0, b_per_viol = 0, b_tog_viol = 0, b_done_cnt = 0;
  bit [15:0] b_bits, b_last_bits;

  always @(negedge clk) begin
    if (!b_cs_n) begin
      if (b_prev_cs) begin
        b_rises = 0;
        b_bits = '0;
      end
      b_cs_low++;
    end else if (!b_prev_cs) begin
      b_last_cs_low = b_cs_low;
      b_cs_low = 0;
      b_last_bits = b_bits;
      b_last_rises = b_rises;
    end
    if (b_sclk && !b_prev_sclk) begin
      if (b_rises > 0 && (cyc - b_last_rise_cyc) != 4) b_per_viol++;
      b_last_rise_cyc = cyc;
      b_rises++;
      b_bits = {b_bits[14:0], b_mosi};
    end
    if (b_sclk && b_prev_sclk && (b_mosi != b_prev_mosi)) b_tog_viol++;
    if (b_rsp_done) b_done_cnt++;
    b_prev_cs = b_cs_n;
    b_prev_sclk = b_sclk;
    b_prev_mosi = b_mosi;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 400) begin step(); n++; end
    if (n >= 400) check_val(tag, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int old);
    int n = 0;
    while (done_cnt == old && n < 400) begin step(); n++; end
    if (n >= 400) check_val(tag, 0, 1);
  endtask

  task automatic issue(input logic rw, input logic [6:0] a, input logic [7:0] d);
    int old;
    old = done_cnt;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    wait_ready("accept_timeout");
    step();
    req_valid = 1'b0; req_addr = 7'h55; req_wdata = 8'hFF; req_rw = ~rw;
    wait_done("done_timeout", old);
  endtask

  initial begin
    int old;
    int n;
    // Reset state
    repeat (3) step();
    check_val("rst_cs_n", cs_n, 1);
    check_val("rst_sclk", sclk, 0);
    check_val("rst_mosi", mosi, 0);
    check_val("rst_done", rsp_done, 0);
    check_val("rst_rdata", rsp_rdata, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    step();
    check_val("idle_ready", req_ready, 1);

    // Reset mid-frame
    old = done_cnt;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h05; req_wdata = 8'hEE;
    wait_ready("accept_timeout");
    step();
    req_valid = 1'b0;
    repeat (59) step();
    check_val("mid_cs_low", cs_n, 0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_cs_n", cs_n, 1);
    check_val("mid_rst_sclk", sclk, 0);
    check_val("mid_rst_mosi", mosi, 0);
    check_val("mid_rst_busy", busy, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Write 0x2A <- 0xC3 (also the normal request after the abort)
    issue(1'b0, 7'h2A, 8'hC3);
    check_val("abort_no_done", done_cnt, old + 1);
    check_val("wr_mosi_bits", last_bits, 16'h54C3);
    check_val("wr_rises", last_rises, 16);
    check_val("wr_cs_low", last_cs_low, 136);
    check_val("wr_latency", done_edge - accept_edge, 136);
    check_val("wr_rdata", done_rdata, 8'h00);

    // Read 0x7F, slave returns 0xA5
    repeat (5) step();
    issue(1'b1, 7'h7F, 8'h3C);
    check_val("rd_mosi_bits", last_bits, 16'hFF00);
    check_val("rd_rdata", done_rdata, 8'hA5);
    check_val("rd_out_hold", rsp_rdata, 8'hA5);

    // Back-to-back: write 0x05 <- 0x11 then read 0x05, req_valid held high
    repeat (5) step();
    ready_in_frame = 0;
    old = done_cnt;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h05; req_wdata = 8'h11;
    wait_ready("accept_timeout");
    step();
    req_rw = 1'b1; req_addr = 7'h05; req_wdata = 8'h77;
    step();
    wait_ready("accept_timeout");
    step();
    req_valid = 1'b0;
    n = 0;
    while (done_cnt < old + 2 && n < 400) begin step(); n++; end
    if (n >= 400) check_val("b2b_timeout", 0, 1);
    check_val("b2b_accept_gap", accept_edge - prev_done_edge, 3);
    check_val("b2b_cs_gap", last_high_run, 3);
    check_val("b2b_ready_in_frame", ready_in_frame, 0);
    check_val("b2b_wr_rdata_kept", prev_done_rdata, 8'hA5);
    check_val("b2b_rd_mosi_bits", last_bits, 16'h0B00);
    check_val("b2b_rd_rdata", done_rdata, 8'h11);

    // CLK_DIV=2 sweep: write 0x33 <- 0x5A
    b_req_valid = 1'b1; b_req_rw = 1'b0; b_req_addr = 7'h33; b_req_wdata = 8'h5A;
    n = 0;
    while (!b_req_ready && n < 400) begin step(); n++; end
    step();
    b_req_valid = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 400) begin step(); n++; end
    if (n >= 400) check_val("b_timeout", 0, 1);
    check_val("b_rises", b_last_rises, 16);
    check_val("b_period_viol", b_per_viol, 0);
    check_val("b_mosi_toggle_hi", b_tog_viol, 0);
    check_val("b_mosi_bits", b_last_bits, 16'h665A);
    check_val("b_cs_low", b_last_cs_low, 68);

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
